// File: rtl/z80_io_pkg.sv
// ============================================================================
// Module  : z80_io_pkg
// Purpose : Shared definitions for the Z80 <-> RISC-V I/O mailbox: Z80-side
//           FSM state encoding, RISC-V register offsets and the bit positions
//           used in the status / trap / interrupt-enable words.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package z80_io_pkg;

    // Z80 access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_TRAP  = 2'd2,
        ST_DONE  = 2'd3
    } z80_state_t;

    // RISC-V word offsets; channel c uses C_RV_CH_BASE+2c (data) and +1 (status)
    localparam logic [5:0] C_RV_TRAP_STAT = 6'd0;
    localparam logic [5:0] C_RV_IRQ_EN    = 6'd1;
    localparam logic [5:0] C_RV_CH_BASE   = 6'd2;

    // Z80 STAT port bits
    localparam int C_ZSTAT_RX_NE = 0;
    localparam int C_ZSTAT_TX_NF = 1;

    // RISC-V channel status sticky bits
    localparam int C_CH_OVF = 0;
    localparam int C_CH_TMO = 1;

    // TRAP_STAT low bits
    localparam int C_TRAP_PEND = 0;
    localparam int C_TRAP_DIR  = 1;

    // IRQ_EN bits
    localparam int C_IRQ_TRAP = 0;
    localparam int C_IRQ_TX   = 1;

    // RISC-V data-register offset of channel c
    function automatic logic [5:0] rv_ch_data_ofs(input int c);
        return C_RV_CH_BASE + 6'(2 * c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_fifo.sv
// ============================================================================
// Module  : io_fifo
// Purpose : Synchronous show-ahead FIFO with occupancy count. A push while
//           full is discarded, a pop while empty is ignored; a push and a pop
//           in the same cycle both take effect.
// Ports   : clk, reset (sync, active-high), i_push/i_pop, i_din -> o_dout
//           (head entry), o_count, o_empty, o_full
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DW-1:0]            i_din,
    output logic [DW-1:0]            o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = r_count[AW];          // count == DEPTH (DEPTH is 2^AW)
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage carries no reset; a flush only clears the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/z80_io_mailbox.sv
// ============================================================================
// Module  : z80_io_mailbox
// Purpose : Byte mailbox between a Z80 I/O bus and a RISC-V register port.
//           NUM_CH channels, each with an RX FIFO (RISC-V -> Z80) and a TX
//           FIFO (Z80 -> RISC-V). Z80 accesses to unmapped ports are trapped
//           and answered by the RISC-V through TRAP_STAT.
// Ports   : clk, reset (sync, active-high)
//           Z80   : z80_iord, z80_iowr, z80adr, z80do -> z80di, z80_io_ready
//           RISC-V: io_valid, rv_adr, rv_wdata, rv_wstr -> rv_rdata, rv_ready
//           irq   : level interrupt to the RISC-V
// Config  : IO_MAILBOX_TIMEOUT_EN - unanswered traps complete with 8'hFF after
//           TIMEOUT_CYCLES and set the channel-0 timeout sticky bit.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_io_mailbox
    import z80_io_pkg::*;
#(
    parameter int         NUM_CH         = 2,
    parameter int         FIFO_DEPTH     = 16,
    parameter logic [7:0] BASE_PORT      = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        z80_iord,
    input  logic        z80_iowr,
    input  logic [7:0]  z80adr,
    input  logic [7:0]  z80do,
    output logic [7:0]  z80di,
    output logic        z80_io_ready,
    input  logic        io_valid,
    input  logic [5:0]  rv_adr,
    input  logic [31:0] rv_wdata,
    input  logic        rv_wstr,
    output logic [31:0] rv_rdata,
    output logic        rv_ready,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- FIFO channel array ----------------
    logic [7:0]        w_rx_dout [NUM_CH];
    logic [7:0]        w_tx_dout [NUM_CH];
    logic [CW-1:0]     w_rx_cnt  [NUM_CH];
    logic [CW-1:0]     w_tx_cnt  [NUM_CH];
    logic [NUM_CH-1:0] w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic [NUM_CH-1:0] w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    logic [7:0]        w_cur_wdata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        io_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_rx (
            .clk(clk), .reset(reset),
            .i_push(w_rx_push[c]), .i_pop(w_rx_pop[c]), .i_din(rv_wdata[7:0]),
            .o_dout(w_rx_dout[c]), .o_count(w_rx_cnt[c]),
            .o_empty(w_rx_empty[c]), .o_full(w_rx_full[c])
        );
        io_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_tx (
            .clk(clk), .reset(reset),
            .i_push(w_tx_push[c]), .i_pop(w_tx_pop[c]), .i_din(w_cur_wdata),
            .o_dout(w_tx_dout[c]), .o_count(w_tx_cnt[c]),
            .o_empty(w_tx_empty[c]), .o_full(w_tx_full[c])
        );
    end

    // ---------------- Z80 side ----------------
    z80_state_t        r_state, w_next;
    logic              r_strb_d, w_strb, w_new, w_z_wr;
    logic [NUM_CH-1:0] w_dec_data, w_dec_stat, r_acc_oh, w_cur_oh;
    logic              w_dec_trap, r_acc_wr, w_cur_wr;
    logic [7:0]        r_acc_wdata;
    logic              w_sel_rx_ne, w_sel_tx_nf, w_stat_rx_ne, w_stat_tx_nf, w_data_go;
    logic [7:0]        w_sel_rx_dout;
    logic              w_di_load, w_acc_latch, w_trap_start, w_trap_clr;
    logic [7:0]        w_di_val;
    logic              r_pending, r_trap_wr;
    logic [7:0]        r_trap_port, r_trap_wdata;
    logic              w_trap_ans, w_to_fire;

    assign w_strb       = z80_iord | z80_iowr;
    assign w_new        = w_strb & ~r_strb_d;
    assign w_z_wr       = z80_iowr & ~z80_iord;
    assign z80_io_ready = (r_state == ST_DONE);

    always_comb begin
        w_dec_data = '0;
        w_dec_stat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_dec_data[c] = (z80adr == BASE_PORT + 8'(2 * c));
            w_dec_stat[c] = (z80adr == BASE_PORT + 8'(2 * c + 1));
        end
    end
    assign w_dec_trap = ~|{w_dec_data, w_dec_stat};

    // A stalled access works from the values latched when it started.
    assign w_cur_oh    = (r_state == ST_IDLE) ? w_dec_data : r_acc_oh;
    assign w_cur_wr    = (r_state == ST_IDLE) ? w_z_wr     : r_acc_wr;
    assign w_cur_wdata = (r_state == ST_IDLE) ? z80do      : r_acc_wdata;

    assign w_sel_rx_ne  = |(w_cur_oh & ~w_rx_empty);
    assign w_sel_tx_nf  = |(w_cur_oh & ~w_tx_full);
    assign w_stat_rx_ne = |(w_dec_stat & ~w_rx_empty);
    assign w_stat_tx_nf = |(w_dec_stat & ~w_tx_full);
    assign w_data_go    = w_cur_wr ? w_sel_tx_nf : w_sel_rx_ne;

    always_comb begin
        w_sel_rx_dout = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_cur_oh[c]) w_sel_rx_dout = w_rx_dout[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_rx_pop     = '0;
        w_tx_push    = '0;
        w_di_load    = 1'b0;
        w_di_val     = '0;
        w_acc_latch  = 1'b0;
        w_trap_start = 1'b0;
        w_trap_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_new) begin
                    w_acc_latch = 1'b1;
                    if (w_dec_trap) begin
                        w_trap_start = 1'b1;
                        w_next       = ST_TRAP;
                    end else if (|w_dec_stat) begin
                        if (!w_z_wr) begin
                            w_di_load                = 1'b1;
                            w_di_val[C_ZSTAT_RX_NE]  = w_stat_rx_ne;
                            w_di_val[C_ZSTAT_TX_NF]  = w_stat_tx_nf;
                        end
                        w_next = ST_DONE;
                    end else begin
                        w_next = w_data_go ? ST_DONE : ST_STALL;
                    end
                end
            end
            ST_STALL: if (w_data_go) w_next = ST_DONE;
            ST_TRAP: begin
                if (w_trap_ans) begin
                    w_di_load  = 1'b1;
                    w_di_val   = rv_wdata[7:0];
                    w_trap_clr = 1'b1;
                    w_next     = ST_DONE;
                end else if (w_to_fire) begin
                    w_di_load  = 1'b1;
                    w_di_val   = 8'hFF;
                    w_trap_clr = 1'b1;
                    w_next     = ST_DONE;
                end
            end
            ST_DONE: if (!z80_iord && !z80_iowr) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase

        // Data-port side effect, either at the start of the access or the
        // first cycle a stalled access can proceed.
        if ((((r_state == ST_IDLE) && w_new && (|w_dec_data)) || (r_state == ST_STALL))
            && w_data_go) begin
            if (w_cur_wr) begin
                w_tx_push = w_cur_oh;
            end else begin
                w_rx_pop  = w_cur_oh;
                w_di_load = 1'b1;
                w_di_val  = w_sel_rx_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z80di        <= '0;
            r_strb_d     <= 1'b0;
            r_acc_oh     <= '0;
            r_acc_wr     <= 1'b0;
            r_acc_wdata  <= '0;
            r_pending    <= 1'b0;
            r_trap_wr    <= 1'b0;
            r_trap_port  <= '0;
            r_trap_wdata <= '0;
        end else begin
            r_strb_d <= w_strb;
            if (w_di_load) z80di <= w_di_val;
            if (w_acc_latch) begin
                r_acc_oh    <= w_dec_data;
                r_acc_wr    <= w_z_wr;
                r_acc_wdata <= z80do;
            end
            if (w_trap_start) begin
                r_trap_port  <= z80adr;
                r_trap_wr    <= w_z_wr;
                r_trap_wdata <= z80do;
                r_pending    <= 1'b1;
            end else if (w_trap_clr) begin
                r_pending <= 1'b0;
            end
        end
    end

    // ---------------- RISC-V side ----------------
    // rv_ready is high exactly in the cycle after the first io_valid cycle,
    // so masking with it isolates the first cycle of each request.
    logic              w_rv_first, w_rv_wr, w_rv_rd;
    logic [NUM_CH-1:0] w_rv_data, w_rv_stat, r_ovf;
    logic [1:0]        r_irq_en;
    logic [31:0]       w_rdata;
    logic              w_timeout;

    assign w_rv_first = io_valid & ~rv_ready;
    assign w_rv_wr    = w_rv_first & rv_wstr;
    assign w_rv_rd    = w_rv_first & ~rv_wstr;
    assign w_trap_ans = w_rv_wr & (rv_adr == C_RV_TRAP_STAT) & r_pending;

    always_comb begin
        w_rv_data = '0;
        w_rv_stat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_rv_data[c] = (rv_adr == rv_ch_data_ofs(c));
            w_rv_stat[c] = (rv_adr == rv_ch_data_ofs(c) + 6'd1);
        end
    end

    assign w_rx_push = {NUM_CH{w_rv_wr}} & w_rv_data;
    assign w_tx_pop  = {NUM_CH{w_rv_rd}} & w_rv_data;

    always_comb begin
        w_rdata = '0;
        if (rv_adr == C_RV_TRAP_STAT) begin
            w_rdata[23:16]      = r_trap_wdata;
            w_rdata[15:8]       = r_trap_port;
            w_rdata[C_TRAP_DIR] = r_trap_wr;
            w_rdata[C_TRAP_PEND]= r_pending;
        end else if (rv_adr == C_RV_IRQ_EN) begin
            w_rdata[1:0] = r_irq_en;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_rv_data[c]) begin
                w_rdata[8]   = ~w_tx_empty[c];
                w_rdata[7:0] = w_tx_dout[c];
            end
            if (w_rv_stat[c]) begin
                w_rdata[23:16]    = 8'(w_rx_cnt[c]);
                w_rdata[15:8]     = 8'(w_tx_cnt[c]);
                w_rdata[C_CH_TMO] = (c == 0) ? w_timeout : 1'b0;
                w_rdata[C_CH_OVF] = r_ovf[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rv_ready <= 1'b0;
            rv_rdata <= '0;
            r_irq_en <= '0;
            r_ovf    <= '0;
        end else begin
            rv_ready <= w_rv_first;
            if (w_rv_first) rv_rdata <= rv_wstr ? 32'h0 : w_rdata;
            if (w_rv_wr && (rv_adr == C_RV_IRQ_EN)) r_irq_en <= rv_wdata[1:0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_rx_push[c] && w_rx_full[c])                 r_ovf[c] <= 1'b1;
                else if (w_rv_wr && w_rv_stat[c] && rv_wdata[C_CH_OVF]) r_ovf[c] <= 1'b0;
            end
        end
    end

`ifdef IO_MAILBOX_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TOW-1:0] r_to_cnt;
    logic           r_timeout;

    assign w_to_fire = (r_state == ST_TRAP) && (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1));
    assign w_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == ST_TRAP) ? r_to_cnt + 1'b1 : '0;
            if ((r_state == ST_TRAP) && w_to_fire && !w_trap_ans) r_timeout <= 1'b1;
            else if (w_rv_wr && w_rv_stat[0] && rv_wdata[C_CH_TMO]) r_timeout <= 1'b0;
        end
    end
`else
    assign w_to_fire = 1'b0;
    assign w_timeout = 1'b0;
`endif

    assign irq = (r_irq_en[C_IRQ_TRAP] & r_pending) | (r_irq_en[C_IRQ_TX] & |(~w_tx_empty));

    logic w_unused;
    assign w_unused = &{1'b0, rv_wdata[31:8], (TIMEOUT_CYCLES > 0)};

endmodule

`default_nettype wire

// File: tb/tb_z80_io_mailbox.sv
// ============================================================================
// Module  : tb_z80_io_mailbox
// Purpose : Directed self-checking bench for z80_io_mailbox (default params:
//           2 channels, 16-deep FIFOs, base port 0x00). Inputs are driven and
//           outputs sampled on the falling clock edge.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z80_io_mailbox;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        z80_iord = 1'b0, z80_iowr = 1'b0;
    logic [7:0]  z80adr = '0, z80do = '0;
    logic [7:0]  z80di;
    logic        z80_io_ready;
    logic        io_valid = 1'b0;
    logic [5:0]  rv_adr = '0;
    logic [31:0] rv_wdata = '0;
    logic        rv_wstr = 1'b0;
    logic [31:0] rv_rdata;
    logic        rv_ready;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    z80_io_mailbox #(.NUM_CH(2), .FIFO_DEPTH(16), .BASE_PORT(8'h00), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .z80_iord(z80_iord), .z80_iowr(z80_iowr), .z80adr(z80adr), .z80do(z80do),
        .z80di(z80di), .z80_io_ready(z80_io_ready),
        .io_valid(io_valid), .rv_adr(rv_adr), .rv_wdata(rv_wdata), .rv_wstr(rv_wstr),
        .rv_rdata(rv_rdata), .rv_ready(rv_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic rv_xfer(input logic wr, input logic [5:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd);
        bit got;
        @(negedge clk);
        io_valid = 1'b1; rv_adr = adr; rv_wdata = wd; rv_wstr = wr;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rv_ready) begin got = 1'b1; break; end
        end
        if (!got) chk("rv_ready_wait", 32'd0, 32'd1);
        rd = rv_rdata;
        io_valid = 1'b0; rv_wstr = 1'b0;
    endtask

    task automatic rv_write(input logic [5:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        rv_xfer(1'b1, adr, wd, dummy);
    endtask

    task automatic rv_chk(input string tag, input logic [5:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        rv_xfer(1'b0, adr, 32'h0, d);
        chk(tag, d, exp);
    endtask

    task automatic z_xfer(input logic wr, input logic [7:0] adr, input logic [7:0] wd,
                          output logic [7:0] rd);
        bit got;
        @(negedge clk);
        z80adr = adr; z80do = wd; z80_iord = ~wr; z80_iowr = wr;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (z80_io_ready) begin got = 1'b1; break; end
        end
        if (!got) chk("z80_ready_wait", 32'd0, 32'd1);
        rd = z80di;
        z80_iord = 1'b0; z80_iowr = 1'b0;
        @(negedge clk);
    endtask

    task automatic z_rd_chk(input string tag, input logic [7:0] adr, input logic [7:0] exp);
        logic [7:0] d;
        z_xfer(1'b0, adr, 8'h00, d);
        chk(tag, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic z_write(input logic [7:0] adr, input logic [7:0] wd);
        logic [7:0] d;
        z_xfer(1'b1, adr, wd, d);
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready",  {31'h0, z80_io_ready}, 32'd0);
        chk("rst_rvrdy",  {31'h0, rv_ready},     32'd0);
        chk("rst_irq",    {31'h0, irq},          32'd0);
        chk("rst_z80di",  {24'h0, z80di},        32'd0);
        chk("rst_rdata",  rv_rdata,              32'd0);
        rv_chk("rst_trapstat", 6'd0, 32'h0);
        rv_chk("rst_irqen",    6'd1, 32'h0);
        rv_chk("rst_ch0stat",  6'd3, 32'h0);

        // ---------------- RX byte delivered in one cycle ----------------
        rv_write(6'd2, 32'h41);
        rv_chk("rx0_cnt1", 6'd3, 32'h0001_0000);
        @(negedge clk);
        z80adr = 8'h00; z80_iord = 1'b1;
        @(negedge clk);
        chk("rd_ready_1cyc", {31'h0, z80_io_ready}, 32'd1);
        chk("rd_data_41",    {24'h0, z80di},        32'h41);
        z80_iord = 1'b0;
        @(negedge clk);
        chk("done_to_idle", {31'h0, z80_io_ready}, 32'd0);
        rv_chk("rx0_cnt0", 6'd3, 32'h0);

        // STAT read: RX empty, TX not full
        z_rd_chk("stat0_empty", 8'h01, 8'h02);

        // ---------------- stalled read released by a push ----------------
        @(negedge clk);
        z80adr = 8'h00; z80_iord = 1'b1;
        repeat (3) @(negedge clk);
        chk("stall_not_ready", {31'h0, z80_io_ready}, 32'd0);
        rv_write(6'd2, 32'h55);
        @(negedge clk);
        chk("stall_ready", {31'h0, z80_io_ready}, 32'd1);
        chk("stall_data",  {24'h0, z80di},        32'h55);
        z80_iord = 1'b0;
        @(negedge clk);

        // ---------------- TX path and TX interrupt ----------------
        z_write(8'h02, 8'h77);
        rv_write(6'd1, 32'h2);
        rv_chk("irqen_rb", 6'd1, 32'h2);
        chk("irq_tx", {31'h0, irq}, 32'd1);
        rv_chk("tx1_cnt", 6'd5, 32'h0000_0100);
        rv_chk("tx1_pop", 6'd4, 32'h0000_0177);
        chk("irq_tx_clr", {31'h0, irq}, 32'd0);
        rv_chk("tx1_pop_empty", 6'd4, 32'h0);
        rv_write(6'd1, 32'h0);

        // ---------------- trap answered by RISC-V ----------------
        rv_write(6'd1, 32'h1);
        @(negedge clk);
        z80adr = 8'h80; z80do = 8'h5A; z80_iowr = 1'b1;
        @(negedge clk);
        chk("trap_irq",      {31'h0, irq},          32'd1);
        chk("trap_notready", {31'h0, z80_io_ready}, 32'd0);
        rv_chk("trap_stat", 6'd0, 32'h005A_8003);
        rv_write(6'd0, 32'h12);
        chk("trap_irq_clr", {31'h0, irq},          32'd0);
        chk("trap_di",      {24'h0, z80di},        32'h12);
        chk("trap_ready",   {31'h0, z80_io_ready}, 32'd1);
        z80_iowr = 1'b0;
        @(negedge clk);
        rv_chk("trap_stat_clr", 6'd0, 32'h005A_8002);
        rv_write(6'd1, 32'h0);

        // ---------------- RX overflow on channel 1 ----------------
        for (int i = 0; i < 17; i++) rv_write(6'd4, 32'(i + 1));
        rv_chk("ovf_set",   6'd5, 32'h0010_0001);
        rv_write(6'd5, 32'h1);
        rv_chk("ovf_clear", 6'd5, 32'h0010_0000);
        for (int i = 0; i < 16; i++) z_rd_chk($sformatf("drain1_%0d", i), 8'h02, 8'(i + 1));
        rv_chk("drain1_cnt", 6'd5, 32'h0);

        // ---------------- simultaneous push and pop on RX0 ----------------
        rv_write(6'd2, 32'hA1);
        rv_write(6'd2, 32'hA2);
        rv_write(6'd2, 32'hA3);
        rv_chk("pp_cnt3", 6'd3, 32'h0003_0000);
        @(negedge clk);
        io_valid = 1'b1; rv_adr = 6'd2; rv_wdata = 32'hA4; rv_wstr = 1'b1;
        z80adr = 8'h00; z80_iord = 1'b1;
        @(negedge clk);
        chk("pp_rvrdy", {31'h0, rv_ready},     32'd1);
        chk("pp_zrdy",  {31'h0, z80_io_ready}, 32'd1);
        chk("pp_data",  {24'h0, z80di},        32'hA1);
        io_valid = 1'b0; rv_wstr = 1'b0; z80_iord = 1'b0;
        rv_chk("pp_cnt_kept", 6'd3, 32'h0003_0000);
        z_rd_chk("pp_ord_a2", 8'h00, 8'hA2);
        z_rd_chk("pp_ord_a3", 8'h00, 8'hA3);
        z_rd_chk("pp_ord_a4", 8'h00, 8'hA4);

        // ---------------- unmapped RISC-V offsets ----------------
        rv_write(6'd10, 32'hFFFF_FFFF);
        rv_chk("unmapped_10", 6'd10, 32'h0);
        rv_chk("unmapped_6",  6'd6,  32'h0);
        rv_chk("unmapped_noalias", 6'd1, 32'h0);

        // ---------------- reset during STALL ----------------
        z_write(8'h00, 8'h99);
        rv_write(6'd4, 32'h11);
        @(negedge clk);
        z80adr = 8'h00; z80_iord = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stall_pre", {31'h0, z80_io_ready}, 32'd0);
        reset = 1'b1; z80_iord = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_ready", {31'h0, z80_io_ready}, 32'd0);
        chk("rst_mid_di",    {24'h0, z80di},        32'd0);
        chk("rst_mid_rdata", rv_rdata,              32'd0);
        rv_chk("rst_mid_ch0", 6'd3, 32'h0);
        rv_chk("rst_mid_ch1", 6'd5, 32'h0);
        z_rd_chk("rst_mid_stat", 8'h01, 8'h02);

`ifdef IO_MAILBOX_TIMEOUT_EN
        // ---------------- unanswered trap times out ----------------
        begin
            bit got;
            @(negedge clk);
            z80adr = 8'h80; z80_iord = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 64 + 16; i++) begin
                @(negedge clk);
                if (z80_io_ready) begin got = 1'b1; break; end
            end
            chk("tmo_ready", {31'h0, got}, 32'd1);
            chk("tmo_di",    {24'h0, z80di}, 32'hFF);
            z80_iord = 1'b0;
            @(negedge clk);
            rv_chk("tmo_sticky", 6'd3, 32'h0000_0002);
            rv_write(6'd3, 32'h2);
            rv_chk("tmo_clear", 6'd3, 32'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
